// File: rtl/axi_lite_bram_slave.sv
`timescale 1ns/1ps
// AXI4-Lite slave backed by a word-addressed on-chip RAM with byte strobes.
// One transaction at a time; read and write share a single FSM.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   s_axi_ar*/s_axi_r*  read address and read data channels
//   s_axi_aw*/s_axi_w*  write address and write data channels
//   s_axi_b*            write response channel
// The ready outputs are combinational from state, arvalid and rst.
module axi_lite_bram_slave #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  localparam int unsigned DEPTH  = 32'd1 << DEPTH_LOG2;
  localparam int unsigned IDX_W  = DEPTH_LOG2;
  localparam int unsigned HI_LSB = DEPTH_LOG2 + 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_MEM     = 3'd1,
    RD_RESP    = 3'd2,
    WR_COLLECT = 3'd3,
    WR_RESP    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [31:0] mem [DEPTH];

  // Latched read request
  logic [IDX_W-1:0] rd_idx_q;
  logic             rd_oor_q;

  // Partially collected write (AW and W may arrive in different cycles)
  logic             aw_got_q, w_got_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic             wr_oor_q;
  logic [31:0]      wr_data_q;
  logic [3:0]       wr_strb_q;

  logic ar_hs_c, aw_hs_c, w_hs_c, commit_c;

  // Address decode of the live channels
  logic [IDX_W-1:0] ar_idx_c, aw_idx_c;
  logic             ar_oor_c, aw_oor_c;

  assign ar_idx_c = s_axi_araddr[DEPTH_LOG2+1:2];
  assign aw_idx_c = s_axi_awaddr[DEPTH_LOG2+1:2];
  assign ar_oor_c = (s_axi_araddr >> HI_LSB) != 32'd0;
  assign aw_oor_c = (s_axi_awaddr >> HI_LSB) != 32'd0;

  // Commit payload: take whichever half handshakes now, else the latched half
  logic [IDX_W-1:0] cm_idx_c;
  logic             cm_oor_c;
  logic [31:0]      cm_data_c;
  logic [3:0]       cm_strb_c;

  assign cm_idx_c  = aw_hs_c ? aw_idx_c    : wr_idx_q;
  assign cm_oor_c  = aw_hs_c ? aw_oor_c    : wr_oor_q;
  assign cm_data_c = w_hs_c  ? s_axi_wdata : wr_data_q;
  assign cm_strb_c = w_hs_c  ? s_axi_wstrb : wr_strb_q;

  // Protection attributes carry no meaning for this memory
  logic unused_prot;
  assign unused_prot = ^{s_axi_arprot, s_axi_awprot};

  // State register
  always_ff @(posedge clk) begin : fsm_state
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, channel readies and handshake strobes
  always_comb begin : fsm_next
    state_d       = state_q;
    s_axi_arready = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    ar_hs_c       = 1'b0;
    aw_hs_c       = 1'b0;
    w_hs_c        = 1'b0;
    commit_c      = 1'b0;
    if (rst) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A same-cycle read wins; AW/W are held off this cycle
          s_axi_arready = 1'b1;
          s_axi_awready = !s_axi_arvalid;
          s_axi_wready  = !s_axi_arvalid;
          if (s_axi_arvalid) begin
            ar_hs_c = 1'b1;
            state_d = RD_MEM;
          end else if (s_axi_awvalid && s_axi_wvalid) begin
            aw_hs_c  = 1'b1;
            w_hs_c   = 1'b1;
            commit_c = 1'b1;
            state_d  = WR_RESP;
          end else if (s_axi_awvalid || s_axi_wvalid) begin
            aw_hs_c = s_axi_awvalid;
            w_hs_c  = s_axi_wvalid;
            state_d = WR_COLLECT;
          end
        end
        RD_MEM: state_d = RD_RESP;
        RD_RESP: begin
          if (s_axi_rvalid && s_axi_rready) state_d = IDLE;
        end
        WR_COLLECT: begin
          s_axi_awready = !aw_got_q;
          s_axi_wready  = !w_got_q;
          aw_hs_c       = !aw_got_q && s_axi_awvalid;
          w_hs_c        = !w_got_q && s_axi_wvalid;
          if (aw_hs_c || w_hs_c) begin
            commit_c = 1'b1;
            state_d  = WR_RESP;
          end
        end
        WR_RESP: begin
          if (s_axi_bvalid && s_axi_bready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Request latches and registered response channels
  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= 32'd0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      aw_got_q     <= 1'b0;
      w_got_q      <= 1'b0;
    end else begin
      if (ar_hs_c) begin
        rd_idx_q <= ar_idx_c;
        rd_oor_q <= ar_oor_c;
      end
      if (aw_hs_c) begin
        wr_idx_q <= aw_idx_c;
        wr_oor_q <= aw_oor_c;
        aw_got_q <= 1'b1;
      end
      if (w_hs_c) begin
        wr_data_q <= s_axi_wdata;
        wr_strb_q <= s_axi_wstrb;
        w_got_q   <= 1'b1;
      end
      if (commit_c) begin
        aw_got_q     <= 1'b0;
        w_got_q      <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= cm_oor_c ? RESP_SLVERR : RESP_OKAY;
      end
      if (state_q == RD_MEM) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_oor_q ? 32'd0 : mem[rd_idx_q];
        s_axi_rresp  <= rd_oor_q ? RESP_SLVERR : RESP_OKAY;
      end
      if (state_q == RD_RESP && s_axi_rready) s_axi_rvalid <= 1'b0;
      if (state_q == WR_RESP && s_axi_bready) s_axi_bvalid <= 1'b0;
    end
  end

  // Byte-lane RAM write; out-of-range writes are discarded
  always_ff @(posedge clk) begin : ram_write
    if (commit_c && !cm_oor_c) begin
      if (cm_strb_c[0]) mem[cm_idx_c][7:0]   <= cm_data_c[7:0];
      if (cm_strb_c[1]) mem[cm_idx_c][15:8]  <= cm_data_c[15:8];
      if (cm_strb_c[2]) mem[cm_idx_c][23:16] <= cm_data_c[23:16];
      if (cm_strb_c[3]) mem[cm_idx_c][31:24] <= cm_data_c[31:24];
    end
  end

endmodule

// File: tb/tb_axi_lite_bram_slave.sv
`timescale 1ns/1ps
// Self-checking bench for axi_lite_bram_slave (DEPTH_LOG2 = 12).
// Expected responses are pushed to queues when a request is issued and
// popped when the DUT answers; a reference word memory tracks contents.
module tb_axi_lite_bram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arprot, awprot;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;

  always #5 clk = ~clk;

  axi_lite_bram_slave #(.DEPTH_LOG2(12), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_bresp(bresp),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  rexp_t       rd_q[$];
  logic [1:0]  b_q[$];
  logic [31:0] model_mem [int];
  int checks = 0;
  int errors = 0;

  // 16 KiB of RAM: anything at or above 0x4000 is out of range
  function automatic bit is_oor(input logic [31:0] a);
    return a >= 32'h0000_4000;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (is_oor(a)) return 32'd0;
    if (model_mem.exists(widx(a))) return model_mem[widx(a)];
    return 32'd0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (is_oor(a)) return;
    w = model_read(a);
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    model_mem[widx(a)] = w;
  endtask

  // Read transaction; acc = cycles to AR handshake, lat = cycles from the
  // handshake cycle to rvalid (-1 on timeout), stable = R held during stall.
  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp,
                         output int acc, output int lat, output bit stable);
    rexp_t e;
    bit hs;
    int n;
    e.data = model_read(addr);
    e.resp = is_oor(addr) ? 2'b10 : 2'b00;
    rd_q.push_back(e);
    araddr = addr; arvalid = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 50) begin #1; hs = arready; @(posedge clk); #1; n++; end
    arvalid = 1'b0;
    acc = n; lat = -1; data = '0; resp = '0; stable = 1'b0;
    if (!hs) return;
    n = 1;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rvalid) return;
    lat = n; data = rdata; resp = rresp; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rvalid || rdata !== data || rresp !== resp) stable = 1'b0;
    end
    rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
  endtask

  // Write transaction; lead = cycles AW precedes W (0 = same cycle).
  // collect_ok drops if readies misbehave or bvalid rises while W is pending.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead,
                          output logic [1:0] resp, output int acc,
                          output int lat, output bit collect_ok);
    bit hs;
    int n;
    b_q.push_back(is_oor(addr) ? 2'b10 : 2'b00);
    model_write(addr, data, strb);
    collect_ok = 1'b1; lat = -1; resp = '0; hs = 1'b0; n = 0;
    if (lead == 0) begin
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      while (!hs && n < 50) begin #1; hs = awready && wready; @(posedge clk); #1; n++; end
      awvalid = 1'b0; wvalid = 1'b0;
      acc = n;
    end else begin
      awaddr = addr; awvalid = 1'b1;
      while (!hs && n < 50) begin #1; hs = awready; @(posedge clk); #1; n++; end
      awvalid = 1'b0;
      acc = n;
      for (int i = 1; i < lead; i++) begin
        #1;
        if (awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0) collect_ok = 1'b0;
        @(posedge clk); #1;
      end
      wdata = data; wstrb = strb; wvalid = 1'b1; hs = 1'b0; n = 0;
      while (!hs && n < 50) begin
        #1; hs = wready;
        if (awready !== 1'b0 || bvalid !== 1'b0) collect_ok = 1'b0;
        @(posedge clk); #1; n++;
      end
      wvalid = 1'b0;
    end
    if (!hs) return;
    n = 1;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bvalid) return;
    lat = n; resp = bresp;
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    arprot = '0; awprot = '0; rready = 1'b0; bready = 1'b0;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({arready, awready, wready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready got %b want 000", {arready, awready, wready});
    end
    checks++;
    if ({rvalid, bvalid} !== 2'b00) begin
      errors++; $display("FAIL reset_valid got %b want 00", {rvalid, bvalid});
    end
    checks++;
    if (rdata !== 32'd0 || rresp !== 2'b00 || bresp !== 2'b00) begin
      errors++; $display("FAIL reset_data got %h/%b/%b want 0", rdata, rresp, bresp);
    end
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({arready, awready, wready} !== 3'b111) begin
      errors++; $display("FAIL idle_ready got %b want 111", {arready, awready, wready});
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] r; int acc, lat; bit ok; rexp_t e; logic [1:0] be;
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, r, acc, lat, ok);
    be = b_q.pop_front();
    checks++;
    if (r !== be) begin errors++; $display("FAIL basic_bresp got %b want %b", r, be); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL basic_blat got %0d want 1", lat); end
    do_read(32'h10, 0, d, r, acc, lat, ok);
    e = rd_q.pop_front();
    checks++;
    if (d !== e.data) begin errors++; $display("FAIL basic_rdata got %h want %h", d, e.data); end
    checks++;
    if (r !== e.resp) begin errors++; $display("FAIL basic_rresp got %b want %b", r, e.resp); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL basic_rlat got %0d want 2", lat); end
  endtask

  task automatic test_strobes();
    logic [31:0] d; logic [1:0] r; int acc, lat; bit ok; rexp_t e; logic [1:0] be;
    do_write(32'h10, 32'h1122_3344, 4'b0101, 0, r, acc, lat, ok);
    be = b_q.pop_front();
    checks++;
    if (r !== be) begin errors++; $display("FAIL strobe_bresp got %b want %b", r, be); end
    do_read(32'h10, 0, d, r, acc, lat, ok);
    e = rd_q.pop_front();
    checks++;
    if (d !== e.data) begin errors++; $display("FAIL strobe_rdata got %h want %h", d, e.data); end
    // wstrb = 0 is an OKAY no-op
    do_write(32'h12, 32'hFFFF_FFFF, 4'b0000, 0, r, acc, lat, ok);
    be = b_q.pop_front();
    checks++;
    if (r !== be) begin errors++; $display("FAIL nostrb_bresp got %b want %b", r, be); end
    do_read(32'h10, 0, d, r, acc, lat, ok);
    e = rd_q.pop_front();
    checks++;
    if (d !== e.data) begin errors++; $display("FAIL nostrb_rdata got %h want %h", d, e.data); end
  endtask

  task automatic test_collect();
    logic [31:0] d; logic [1:0] r; int acc, lat; bit ok; rexp_t e; logic [1:0] be;
    do_write(32'h20, 32'h0000_CAFE, 4'hF, 3, r, acc, lat, ok);
    be = b_q.pop_front();
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL collect_ready got %b want 1", ok); end
    checks++;
    if (r !== be) begin errors++; $display("FAIL collect_bresp got %b want %b", r, be); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL collect_blat got %0d want 1", lat); end
    do_read(32'h20, 0, d, r, acc, lat, ok);
    e = rd_q.pop_front();
    checks++;
    if (d !== e.data) begin errors++; $display("FAIL collect_rdata got %h want %h", d, e.data); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int acc, lat; bit ok; rexp_t e; logic [1:0] be;
    do_write(32'h0, 32'h5A5A_1234, 4'hF, 0, r, acc, lat, ok);
    be = b_q.pop_front();
    checks++;
    if (r !== be) begin errors++; $display("FAIL w0_bresp got %b want %b", r, be); end
    do_read(32'h0001_0000, 0, d, r, acc, lat, ok);
    e = rd_q.pop_front();
    checks++;
    if (d !== e.data || r !== e.resp) begin
      errors++; $display("FAIL oor_read got %h/%b want %h/%b", d, r, e.data, e.resp);
    end
    do_write(32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 0, r, acc, lat, ok);
    be = b_q.pop_front();
    checks++;
    if (r !== be) begin errors++; $display("FAIL oor_bresp got %b want %b", r, be); end
    do_read(32'h0, 0, d, r, acc, lat, ok);
    e = rd_q.pop_front();
    checks++;
    if (d !== e.data) begin errors++; $display("FAIL oor_word0 got %h want %h", d, e.data); end
  endtask

  task automatic test_collision();
    logic [31:0] d, held; logic [1:0] r; int acc, lat, n; bit ok, hs; rexp_t e; logic [1:0] be;
    e.data = model_read(32'h10); e.resp = 2'b00; rd_q.push_back(e);
    b_q.push_back(2'b00); model_write(32'h14, 32'hA5A5_0F0F, 4'hF);
    araddr = 32'h10; arvalid = 1'b1;
    awaddr = 32'h14; wdata = 32'hA5A5_0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    checks++;
    if ({arready, awready, wready} !== 3'b100) begin
      errors++; $display("FAIL collide_ready got %b want 100", {arready, awready, wready});
    end
    @(posedge clk); #1; arvalid = 1'b0;
    ok = 1'b1; n = 1;
    while (!rvalid && n < 50) begin
      #1; if (awready || wready || bvalid) ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== 2) begin errors++; $display("FAIL collide_rlat got %0d want 2", n); end
    held = rdata; r = rresp;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!rvalid || rdata !== held || rresp !== r || awready || wready || bvalid) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL collide_stall got %b want 1", ok); end
    e = rd_q.pop_front();
    checks++;
    if (held !== e.data || r !== e.resp) begin
      errors++; $display("FAIL collide_rdata got %h/%b want %h/%b", held, r, e.data, e.resp);
    end
    rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin #1; hs = awready && wready; @(posedge clk); #1; n++; end
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (n !== 1) begin errors++; $display("FAIL collide_waccept got %0d want 1", n); end
    n = 1;
    while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
    be = b_q.pop_front();
    checks++;
    if (bvalid !== 1'b1 || bresp !== be) begin
      errors++; $display("FAIL collide_b got %b/%b want 1/%b", bvalid, bresp, be);
    end
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
    do_read(32'h14, 0, d, r, acc, lat, ok);
    e = rd_q.pop_front();
    checks++;
    if (d !== e.data) begin errors++; $display("FAIL collide_readback got %h want %h", d, e.data); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int acc, lat, n; bit ok; rexp_t e; logic [1:0] be;
    // Abandon a read in RD_RESP
    araddr = 32'h10; arvalid = 1'b1;
    #1; @(posedge clk); #1; arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
    rst = 1'b1; @(posedge clk); #1;
    checks++;
    if ({rvalid, bvalid} !== 2'b00) begin
      errors++; $display("FAIL rstrd_valid got %b want 00", {rvalid, bvalid});
    end
    rst = 1'b0; #1;
    checks++;
    if (arready !== 1'b1) begin errors++; $display("FAIL rstrd_idle got %b want 1", arready); end
    ok = 1'b1; rready = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (rvalid || bvalid) ok = 1'b0; end
    rready = 1'b0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL rstrd_stray got %b want 1", ok); end
    // Abandon a write in WR_COLLECT
    do_write(32'h30, 32'h1111_1111, 4'hF, 0, r, acc, lat, ok);
    be = b_q.pop_front();
    checks++;
    if (r !== be) begin errors++; $display("FAIL rstwr_pre got %b want %b", r, be); end
    awaddr = 32'h30; awvalid = 1'b1;
    #1; @(posedge clk); #1; awvalid = 1'b0;
    wdata = 32'h2222_2222; wstrb = 4'hF;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; #1;
    checks++;
    if ({awready, wready, bvalid} !== 3'b110) begin
      errors++; $display("FAIL rstwr_idle got %b want 110", {awready, wready, bvalid});
    end
    ok = 1'b1; bready = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (bvalid || rvalid) ok = 1'b0; end
    bready = 1'b0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL rstwr_stray got %b want 1", ok); end
    do_read(32'h30, 0, d, r, acc, lat, ok);
    e = rd_q.pop_front();
    checks++;
    if (d !== e.data) begin errors++; $display("FAIL rstwr_old got %h want %h", d, e.data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, a; logic [1:0] r; int acc, lat; bit ok; rexp_t e; logic [1:0] be;
    for (int i = 0; i < 16; i++) begin
      do_write(32'h100 + 32'(4 * i), $urandom, 4'hF, 0, r, acc, lat, ok);
      be = b_q.pop_front();
      if (r !== be) begin checks++; errors++; $display("FAIL b2b_init%0d got %b want %b", i, r, be); end
    end
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h0002_0100 : 32'h100 + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), r, acc, lat, ok);
        be = b_q.pop_front();
        checks++;
        if (r !== be || lat !== 1 || acc !== 1) begin
          errors++; $display("FAIL b2b_w%0d got %b/%0d/%0d want %b/1/1", i, r, lat, acc, be);
        end
      end else begin
        do_read(a, $urandom_range(0, 2), d, r, acc, lat, ok);
        e = rd_q.pop_front();
        checks++;
        if (d !== e.data || r !== e.resp || lat !== 2 || acc !== 1 || !ok) begin
          errors++;
          $display("FAIL b2b_r%0d got %h/%b/%0d/%0d want %h/%b/2/1", i, d, r, lat, acc, e.data, e.resp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strobes();
    test_collect();
    test_out_of_range();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
